matmul_calc_engine: RTL and testbench

- Parametrised compute core of the APB matrix engine.
- Latches A (N×K), B (K×M) and an optional bias matrix on start, then computes C = A·B (+bias) one element at a time.
- Streams each element with a valid/ready handshake, tagged with row, column and scratchpad target, for the write-back logic.
- Successor to the fixed 4×4 datapath: dimensions are set per operation, signed/unsigned mode, bias accumulation, overflow flags and abort.

---
 rtl/matmul_calc_engine.sv | 162 ++++++++++++++++
 tb/tb_matmul_calc_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_calc_engine.sv
// Sequential matrix-multiply core: one C[row][col] per CALC/OUT pair, streamed row-major.
// Build option MATMUL_SATURATE_EN clamps overflowing results instead of wrapping them.
module matmul_calc_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  parameter int SP_NTARGETS = 4,
  localparam int DIM_W = $clog2(MAX_DIM),
  localparam int TGT_W = $clog2(SP_NTARGETS)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic                                   abort_i,
  input  logic [DIM_W-1:0]                       dim_n_i,
  input  logic [DIM_W-1:0]                       dim_k_i,
  input  logic [DIM_W-1:0]                       dim_m_i,
  input  logic                                   signed_i,
  input  logic                                   bias_en_i,
  input  logic [TGT_W-1:0]                       sp_target_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  a_mat_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]  b_mat_i,
  input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]   bias_mat_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   res_valid_o,
  input  logic                                   res_ready_i,
  output logic [BUS_WIDTH-1:0]                   res_data_o,
  output logic [DIM_W-1:0]                       res_row_o,
  output logic [DIM_W-1:0]                       res_col_o,
  output logic [TGT_W-1:0]                       res_target_o,
  output logic [MAX_DIM*MAX_DIM-1:0]             ovf_o
);

  localparam int ACC_W = BUS_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q    [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0]   a_d    [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0]   b_q    [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0]   b_d    [MAX_DIM][MAX_DIM];
  logic [BUS_WIDTH-1:0]    bias_q [MAX_DIM][MAX_DIM];
  logic [BUS_WIDTH-1:0]    bias_d [MAX_DIM][MAX_DIM];
  logic                    ovf_q  [MAX_DIM][MAX_DIM];
  logic                    ovf_d  [MAX_DIM][MAX_DIM];
  logic [DIM_W-1:0]        dn_q, dn_d, dk_q, dk_d, dm_q, dm_d;
  logic [DIM_W-1:0]        row_q, row_d, col_q, col_d;
  logic                    sgn_q, sgn_d, be_q, be_d;
  logic [TGT_W-1:0]        tgt_q, tgt_d;
  logic [BUS_WIDTH-1:0]    data_q, data_d;

  logic signed [ACC_W-1:0] acc;
  logic                    ovf_hit;
  logic [BUS_WIDTH-1:0]    res_val;

  function automatic logic signed [ACC_W-1:0] ext_op(input logic [DATA_WIDTH-1:0] v, input logic s);
    return s ? {{(ACC_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v} : {{(ACC_W-DATA_WIDTH){1'b0}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_bias(input logic [BUS_WIDTH-1:0] v, input logic s);
    return s ? {{(ACC_W-BUS_WIDTH){v[BUS_WIDTH-1]}}, v} : {{(ACC_W-BUS_WIDTH){1'b0}}, v};
  endfunction

  // ACC_W holds the exact value in both modes, so overflow is read off the top bits.
  always_comb begin
    acc = '0;
    for (int k = 0; k < MAX_DIM; k++) begin
      if (k[DIM_W-1:0] <= dk_q)
        acc = acc + ext_op(a_q[row_q][k[DIM_W-1:0]], sgn_q) * ext_op(b_q[k[DIM_W-1:0]][col_q], sgn_q);
    end
    if (be_q) acc = acc + ext_bias(bias_q[row_q][col_q], sgn_q);
  end

  always_comb begin
    if (sgn_q) ovf_hit = !((&acc[ACC_W-1:BUS_WIDTH-1]) || !(|acc[ACC_W-1:BUS_WIDTH-1]));
    else       ovf_hit = |acc[ACC_W-1:BUS_WIDTH];
    res_val = acc[BUS_WIDTH-1:0];
`ifdef MATMUL_SATURATE_EN
    if (ovf_hit) begin
      if (!sgn_q)          res_val = '1;
      else if (acc[ACC_W-1]) res_val = {1'b1, {(BUS_WIDTH-1){1'b0}}};
      else                 res_val = {1'b0, {(BUS_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d = a_q;  b_d = b_q;  bias_d = bias_q;  ovf_d = ovf_q;
    dn_d = dn_q;  dk_d = dk_q;  dm_d = dm_q;
    row_d = row_q;  col_d = col_q;
    sgn_d = sgn_q;  be_d = be_q;  tgt_d = tgt_q;
    data_d = data_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        for (int r = 0; r < MAX_DIM; r++)
          for (int c = 0; c < MAX_DIM; c++) begin
            a_d[r][c]    = a_mat_i[(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
            b_d[r][c]    = b_mat_i[(r*MAX_DIM+c)*DATA_WIDTH +: DATA_WIDTH];
            bias_d[r][c] = bias_mat_i[(r*MAX_DIM+c)*BUS_WIDTH +: BUS_WIDTH];
            ovf_d[r][c]  = 1'b0;
          end
        dn_d = dim_n_i;  dk_d = dim_k_i;  dm_d = dim_m_i;
        sgn_d = signed_i;  be_d = bias_en_i;  tgt_d = sp_target_i;
        row_d = '0;  col_d = '0;
        state_d = S_CALC;
      end
      S_CALC: if (abort_i) state_d = S_IDLE;
              else begin
                data_d = res_val;
                if (ovf_hit) ovf_d[row_q][col_q] = 1'b1;
                state_d = S_OUT;
              end
      S_OUT: if (abort_i) state_d = S_IDLE;
             else if (res_ready_i) begin
               if (col_q < dm_q) begin
                 col_d = col_q + 1'b1;  state_d = S_CALC;
               end else if (row_q < dn_q) begin
                 col_d = '0;  row_d = row_q + 1'b1;  state_d = S_CALC;
               end else state_d = S_DONE;
             end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q <= '{default: '0};  b_q <= '{default: '0};
      bias_q <= '{default: '0};  ovf_q <= '{default: '0};
      dn_q <= '0;  dk_q <= '0;  dm_q <= '0;
      row_q <= '0;  col_q <= '0;
      sgn_q <= 1'b0;  be_q <= 1'b0;  tgt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;  b_q <= b_d;  bias_q <= bias_d;  ovf_q <= ovf_d;
      dn_q <= dn_d;  dk_q <= dk_d;  dm_q <= dm_d;
      row_q <= row_d;  col_q <= col_d;
      sgn_q <= sgn_d;  be_q <= be_d;  tgt_q <= tgt_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    ovf_o = '0;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        ovf_o[r*MAX_DIM+c] = ovf_q[r][c];
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign res_valid_o  = (state_q == S_OUT);
  assign res_data_o   = data_q;
  assign res_row_o    = row_q;
  assign res_col_o    = col_q;
  assign res_target_o = tgt_q;

endmodule

// File: tb/tb_matmul_calc_engine.sv
// Bench for matmul_calc_engine: directed table, handshake/abort/reset sequences, random ops vs a plain-arithmetic model.
module tb_matmul_calc_engine;
  logic         clk_i = 1'b0;
  logic         rst_i, start_i, abort_i, signed_i, bias_en_i, res_ready_i;
  logic [1:0]   dim_n_i, dim_k_i, dim_m_i, sp_target_i;
  logic [127:0] a_mat_i, b_mat_i;
  logic [511:0] bias_mat_i;
  logic         busy_o, done_o, res_valid_o;
  logic [31:0]  res_data_o;
  logic [1:0]   res_row_o, res_col_o, res_target_o;
  logic [15:0]  ovf_o;

  matmul_calc_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i),
    .signed_i(signed_i), .bias_en_i(bias_en_i), .sp_target_i(sp_target_i),
    .a_mat_i(a_mat_i), .b_mat_i(b_mat_i), .bias_mat_i(bias_mat_i),
    .busy_o(busy_o), .done_o(done_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_row_o(res_row_o), .res_col_o(res_col_o),
    .res_target_o(res_target_o), .ovf_o(ovf_o));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  logic [7:0]  a_m [4][4];
  logic [7:0]  b_m [4][4];
  logic [31:0] bias_m [4][4];
  logic [31:0] exp_d [16];
  logic        exp_ov [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact value with plain 64-bit integers, then wrap or clamp to 32 bits.
  function automatic void model(input int r, c, k, input bit sgn, be,
                                output logic [31:0] d, output bit ov);
    longint s = 0;
    longint av, bv;
    for (int i = 0; i <= k; i++) begin
      av = sgn ? longint'(signed'(a_m[r][i])) : longint'(a_m[r][i]);
      bv = sgn ? longint'(signed'(b_m[i][c])) : longint'(b_m[i][c]);
      s += av * bv;
    end
    if (be) s += sgn ? longint'(signed'(bias_m[r][c])) : longint'(bias_m[r][c]);
    ov = sgn ? (s > 64'sd2147483647 || s < -64'sd2147483648) : (s > 64'sd4294967295);
    d = s[31:0];
`ifdef MATMUL_SATURATE_EN
    if (ov) d = !sgn ? 32'hFFFF_FFFF : (s < 0 ? 32'h8000_0000 : 32'h7FFF_FFFF);
`endif
  endfunction

  // kill_mode: 0 none, 1 abort, 2 reset, applied when element kill_e is presented.
  task automatic run_op(input int n, k, m, input bit sgn, be, input logic [1:0] tgt,
                        input bit rnd_rdy, input int stall_e, stall_len,
                        input int kill_e, kill_mode, input bit abort_at_start,
                        output logic [31:0] first_d);
    int ne, e, cyc, prev_hs, stall_cnt, r, c;
    bit seen, rdy, killed;
    logic [15:0] ov_exp;
    ne = (n + 1) * (m + 1);
    for (int i = 0; i < ne; i++) model(i / (m + 1), i % (m + 1), k, sgn, be, exp_d[i], exp_ov[i]);
    for (int i = 0; i < 16; i++) begin
      a_mat_i[i*8 +: 8] = a_m[i/4][i%4];
      b_mat_i[i*8 +: 8] = b_m[i/4][i%4];
      bias_mat_i[i*32 +: 32] = bias_m[i/4][i%4];
    end
    dim_n_i = n[1:0]; dim_k_i = k[1:0]; dim_m_i = m[1:0];
    signed_i = sgn; bias_en_i = be; sp_target_i = tgt;
    start_i = 1'b1; abort_i = abort_at_start; res_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    dim_n_i = ~dim_n_i; sp_target_i = ~tgt; signed_i = ~sgn;  // latched copies must be used
    cyc = 1;
    chk("busy_after_start", busy_o, 1);
    chk("valid_in_calc", res_valid_o, 0);
    e = 0; prev_hs = -1; stall_cnt = 0; seen = 0; killed = 0; first_d = 'x;
    while (e < ne && cyc < 400 && !killed) begin
      rdy = rnd_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
      if (res_valid_o) begin
        r = e / (m + 1); c = e % (m + 1);
        if (!seen) begin chk("first_valid_latency", cyc, 2); seen = 1; end
        chk("data", res_data_o, exp_d[e]);
        chk("row", res_row_o, r[1:0]);
        chk("col", res_col_o, c[1:0]);
        chk("target", res_target_o, tgt);
        chk("no_early_done", done_o, 0);
        if (e == stall_e && stall_cnt < stall_len) begin rdy = 1'b0; stall_cnt++; end
        if (e == kill_e) begin
          killed = 1; rdy = 1'b0;
          if (kill_mode == 1) abort_i = 1'b1; else rst_i = 1'b1;
        end
        res_ready_i = rdy;
        if (rdy) begin
          if (!rnd_rdy && stall_e < 0 && prev_hs >= 0) chk("throughput", cyc - prev_hs, 2);
          if (e == 0) first_d = res_data_o;
          prev_hs = cyc; e++;
        end
      end else res_ready_i = rdy;
      @(negedge clk_i); cyc++;
    end
    res_ready_i = 1'b0; abort_i = 1'b0; rst_i = 1'b0;
    if (killed) begin
      ov_exp = '0;
      if (kill_mode == 1)
        for (int i = 0; i <= kill_e; i++) ov_exp[(i/(m+1))*4 + i%(m+1)] = exp_ov[i];
      chk("kill_busy", busy_o, 0);
      chk("kill_valid", res_valid_o, 0);
      chk("kill_done", done_o, 0);
      chk("kill_ovf", ovf_o, ov_exp);
      if (kill_mode == 2) begin
        chk("rst_data", res_data_o, 0);
        chk("rst_rowcol", {res_row_o, res_col_o, res_target_o}, 0);
      end
      @(negedge clk_i);
      chk("kill_no_late_done", done_o, 0);
    end else if (e < ne) begin
      chk("timeout_handshakes", e, ne);
    end else begin
      chk("done_pulse", done_o, 1);
      chk("done_busy", busy_o, 1);
      chk("done_valid", res_valid_o, 0);
      @(negedge clk_i);
      chk("done_once", done_o, 0);
      chk("idle_busy", busy_o, 0);
      ov_exp = '0;
      for (int i = 0; i < ne; i++) ov_exp[(i/(m+1))*4 + i%(m+1)] = exp_ov[i];
      chk("ovf", ovf_o, ov_exp);
    end
  endtask

  task automatic fill(input logic [7:0] av, bv, input logic [31:0] biasv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a_m[r][c] = av; b_m[r][c] = bv; bias_m[r][c] = biasv;
      end
  endtask

  typedef struct {
    int n, k, m; bit sgn, be;
    logic [7:0] av, bv; logic [31:0] biasv;
    logic [31:0] exp_data; bit exp_ovf0;
  } vec_t;

  vec_t tbl[7];
  logic [31:0] fd;

  initial begin
`ifdef MATMUL_SATURATE_EN
    tbl[0] = '{0,0,0, 1'b0,1'b1, 8'hFF,8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[1] = '{0,0,0, 1'b1,1'b1, 8'h7F,8'h7F, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    tbl[2] = '{0,0,0, 1'b1,1'b1, 8'h80,8'h7F, 32'h8000_0000, 32'h8000_0000, 1'b1};
`else
    tbl[0] = '{0,0,0, 1'b0,1'b1, 8'hFF,8'hFF, 32'hFFFF_FFFF, 32'h0000_FE00, 1'b1};
    tbl[1] = '{0,0,0, 1'b1,1'b1, 8'h7F,8'h7F, 32'h7FFF_FFFF, 32'h8000_3F00, 1'b1};
    tbl[2] = '{0,0,0, 1'b1,1'b1, 8'h80,8'h7F, 32'h8000_0000, 32'h7FFF_C080, 1'b1};
`endif
    tbl[3] = '{3,3,3, 1'b1,1'b0, 8'h80,8'h80, 32'h0, 32'h0001_0000, 1'b0};
    tbl[4] = '{3,3,3, 1'b0,1'b0, 8'hFF,8'hFF, 32'h0, 32'h0003_F804, 1'b0};
    tbl[5] = '{1,1,1, 1'b1,1'b1, 8'h7F,8'h80, 32'h7FFF_FFFF, 32'h7FFF_80FF, 1'b0};
    tbl[6] = '{2,0,1, 1'b0,1'b1, 8'h03,8'h05, 32'd10, 32'd25, 1'b0};

    rst_i = 1'b1; start_i = 0; abort_i = 0; res_ready_i = 0;
    dim_n_i = 0; dim_k_i = 0; dim_m_i = 0; signed_i = 0; bias_en_i = 0; sp_target_i = 0;
    a_mat_i = '0; b_mat_i = '0; bias_mat_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset_busy", busy_o, 0);
    chk("reset_outs", {done_o, res_valid_o, res_data_o, res_row_o, res_col_o, res_target_o}, 0);
    chk("reset_ovf", ovf_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      fill(tbl[i].av, tbl[i].bv, tbl[i].biasv);
      run_op(tbl[i].n, tbl[i].k, tbl[i].m, tbl[i].sgn, tbl[i].be, 2'(i), 0, -1, 0, -1, 0, 0, fd);
      chk($sformatf("tbl%0d_data", i), fd, tbl[i].exp_data);
      chk($sformatf("tbl%0d_ovf0", i), ovf_o[0], tbl[i].exp_ovf0);
    end

    // identity multiply, then the same with a 5-cycle stall on (0,1)
    fill(8'h0, 8'h0, 32'h0);
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 1; b_m[1][1] = 1;
    run_op(1, 1, 1, 0, 0, 2'd1, 0, -1, 0, -1, 0, 0, fd);
    chk("ident_00", fd, 32'd1);
    run_op(1, 1, 1, 0, 0, 2'd2, 0, 1, 5, -1, 0, 0, fd);

    // abort on (0,2) of a 3x3x3, then a full rerun with abort_i held during the IDLE start
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a_m[r][c] = 8'(r*3 + c + 1); b_m[r][c] = 8'(c*2 + r + 1); bias_m[r][c] = 0;
      end
    run_op(2, 2, 2, 0, 0, 2'd3, 0, -1, 0, 2, 1, 0, fd);
    run_op(2, 2, 2, 0, 0, 2'd3, 0, -1, 0, -1, 0, 1, fd);
    // reset during OUT of element (1,0), then a normal run
    run_op(2, 2, 2, 1, 0, 2'd1, 0, -1, 0, 3, 2, 0, fd);
    run_op(2, 2, 2, 1, 0, 2'd1, 0, -1, 0, -1, 0, 0, fd);

    for (int t = 0; t < 25; t++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          a_m[r][c] = 8'($urandom); b_m[r][c] = 8'($urandom);
          case ($urandom_range(0, 3))
            0: bias_m[r][c] = 32'h7FFF_0000 + 32'($urandom_range(0, 16'hFFFF));
            1: bias_m[r][c] = 32'h8000_0000 + 32'($urandom_range(0, 16'hFFFF));
            2: bias_m[r][c] = 32'hFFFF_0000 + 32'($urandom_range(0, 16'hFFFF));
            default: bias_m[r][c] = $urandom;
          endcase
        end
      run_op($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 2'($urandom), 1, -1, 0, -1, 0, 0, fd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
